des_round_engine: RTL and testbench
===================================

# des_round_engine

Iterative 16-round DES Feistel core with an on-the-fly key schedule. It sits between the initial-permutation stage and the final-permutation stage. It accepts a 64-bit block that has already been initial-permuted, plus a 64-bit key, and runs one round per clock. It presents the swapped pre-output R16‖L16, which feeds the final permutation directly. Encrypt and decrypt share the datapath; only subkey order differs.

## Interface
Parameters: none. Bit numbering everywhere: vector index i carries DES standard bit i+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input block and key valid
- in_ready  out  1  engine can accept; high only in IDLE
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on acceptance
- ip_text  in  64  post-IP block; [31:0] = L0, [63:32] = R0
- key  in  64  DES key; parity bits (indices 7, 15, …, 63) ignored; sampled on acceptance
- out_valid  out  1  preoutput valid; held until taken
- out_ready  in  1  downstream accepts preoutput
- preoutput  out  64  [31:0] = R16, [63:32] = L16 (swapped order expected by final permutation)
- busy  out  1  high in RUN

## Operation
- FSM states:
  - IDLE: in_ready = 1. If in_valid = 1, go to RUN.
  - RUN: exactly 16 cycles, then go to DONE.
  - DONE: out_valid = 1. If out_ready = 1, go to IDLE.
- Acceptance (IDLE && in_valid):
  - Register L = ip_text[31:0] and R = ip_text[63:32].
  - Register CD = PC-1(key): C = 28 bits, D = 28 bits.
  - Register mode = decrypt. Set round = 0 (4-bit counter).
- One round per RUN cycle, round n = round + 1:
  - Subkey: encrypt uses CD' = CD rotated left by shift[n]; decrypt round 1 uses CD' = CD unchanged; decrypt rounds 2–16 use CD' = CD rotated right by shift[18−n].
  - shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The first decrypt subkey equals K16 because total encrypt rotation is 28.
  - "Rotate left" is in DES bit terms: C'[i] = C[(i+s) mod 28] in vector indices. "Rotate right" is the inverse.
  - K = PC-2(CD'), 48 bits. Register CD ← CD'.
  - L ← R; R ← L XOR f(R, K). f = expansion E, XOR with K, S1..S8, permutation P.
  - round increments 0→15; RUN exits after the edge where round = 15.
- preoutput = {L, R} continuously. After round 16, L register holds L16 and R holds R16. Pin mapping makes [31:0] = R16 and [63:32] = L16. No extra swap register.
- in_valid is ignored outside IDLE.
- Changes on ip_text, key, and decrypt after acceptance have no effect.
- DONE with out_ready low: preoutput and out_valid stay stable indefinitely.

## Timing
- Reset: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, L = R = 0, CD = 0, round = 0, preoutput = 0.
- Latency: accept at edge T0; RUN occupies edges T1..T16; out_valid is high after edge T16.
- Handshake: the output is taken at the edge where out_valid && out_ready. in_ready rises the following cycle.
- Minimum issue interval is 18 cycles with out_ready tied high.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values. No output is produced for the aborted block.
- f-function plus PC-2 form one combinational round path; no pipelining inside a round.

## Test plan
- Bench wraps the engine with the team's initial- and final-permutation stages and maps standard hex bit n to index n−1.
- Encrypt: key 133457799BBCDFF1, plaintext 0123456789ABCDEF, out_ready high → out_valid exactly 16 cycles after accept; ciphertext 85E813540F0AB405; in_ready low during RUN/DONE.
- Decrypt: key 133457799BBCDFF1, ciphertext 85E813540F0AB405 → plaintext 0123456789ABCDEF. Key 0E329232EA6D0D73 with ciphertext 0000000000000000 → 8787878787878787.
- Backpressure: out_ready low for 10 cycles after out_valid → preoutput stable, out_valid held; in_valid pulses during this window are ignored. Release → one transfer, then IDLE.
- Reset mid-operation: assert rst at RUN cycle 7 → next sample shows out_valid = 0, preoutput = 0, in_ready = 1. A fresh encrypt of the first vector still yields 85E813540F0AB405.
- Back-to-back: two encrypts with different keys and inputs changed on the cycle after acceptance → both outputs match the software model. Encrypt-then-decrypt round trip on 1000 random key/block pairs returns the original block.

Source files
------------

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock between the IP and FP stages.
// Subkeys are produced on the fly; decrypt walks the key schedule backwards.
module des_round_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] ip_text,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] preoutput,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // All tables are 1-based DES bit numbers; vector index = bit number - 1.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Entry 0 of each box is the leftmost nibble; entry index = {row, col}.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};
    // Rounds (indexed by round_q) that rotate by one instead of two.
    localparam logic [15:0] ENC1 = 16'b1000_0001_0000_0011;
    localparam logic [15:0] DEC1 = 16'b1000_0001_0000_0010;

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    state_t      state_q;
    logic [31:0] l_q, r_q, r_d;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [3:0]  round_q;
    logic        mode_q, in_ready_q, out_valid_q, busy_q;
    logic [55:0] pc1, cdn;
    logic [47:0] er, kdat, xk;
    logic [31:0] sout, fout;
    logic        unused_parity;

    assign unused_parity = ^{key[63], key[55], key[47], key[39],
                             key[31], key[23], key[15], key[7]};

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        localparam int K = PC1_T[g] - 1;
        assign pc1[g] = key[K];
    end

    // Decrypt round 1 reuses CD0 unchanged: it already equals CD16.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (!mode_q) begin
            c_d = rotl(c_q, !ENC1[round_q]);
            d_d = rotl(d_q, !ENC1[round_q]);
        end else if (round_q != 4'd0) begin
            c_d = rotr(c_q, !DEC1[round_q]);
            d_d = rotr(d_q, !DEC1[round_q]);
        end
    end

    assign cdn = {d_d, c_d};

    for (genvar g = 0; g < 48; g++) begin : g_pc2_e
        localparam int K = PC2_T[g] - 1;
        localparam int X = E_T[g] - 1;
        assign kdat[g] = cdn[K];
        assign er[g]   = r_q[X];
    end

    assign xk = er ^ kdat;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        logic [5:0] b;
        logic [5:0] idx;
        logic [7:0] off;
        logic [3:0] v;
        assign b   = xk[6*g +: 6];
        assign idx = {b[0], b[5], b[1], b[2], b[3], b[4]};
        assign off = {~idx, 2'b00};
        assign v   = SBOX[g][off +: 4];
        assign sout[4*g +: 4] = {v[0], v[1], v[2], v[3]};
    end

    for (genvar g = 0; g < 32; g++) begin : g_p
        localparam int K = P_T[g] - 1;
        assign fout[g] = sout[K];
    end

    assign r_d = l_q ^ fout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            round_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    l_q        <= ip_text[31:0];
                    r_q        <= ip_text[63:32];
                    c_q        <= pc1[27:0];
                    d_q        <= pc1[55:28];
                    mode_q     <= decrypt;
                    round_q    <= '0;
                    state_q    <= RUN;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    l_q     <= r_q;
                    r_q     <= r_d;
                    c_q     <= c_d;
                    d_q     <= d_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'd15) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // L sits in the upper half, giving the swapped R16||L16 order on the bus.
    assign preoutput = {l_q, r_q};
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: wraps it with IP/FP, checks every cycle against
// a textbook DES model (MSB-first hex, precomputed subkey list).
module tb_des_round_engine;
    logic        clk, rst, in_valid, in_ready, decrypt, out_valid, out_ready, busy;
    logic [63:0] ip_text, key, preoutput;

    des_round_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .decrypt(decrypt), .ip_text(ip_text), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .preoutput(preoutput), .busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                      57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                     12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                     24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                       10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                       14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                       26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                       51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [255:0] SB_H [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic int tab(input int sel, input int j);
        case (sel)
            0: return IP_T[j];
            1: return FP_T[j];
            2: return E_T[j];
            3: return P_T[j];
            4: return PC1_T[j];
            default: return PC2_T[j];
        endcase
    endfunction

    // Values are MSB-first: standard bit b of an inw-bit value is v[inw-b].
    function automatic logic [63:0] perm(input int sel, input logic [63:0] v,
                                         input int inw, input int n);
        logic [63:0] o;
        o = '0;
        for (int j = 1; j <= n; j++) o[n-j] = v[inw - tab(sel, j-1)];
        return o;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[i] = v[63-i];
        return o;
    endfunction

    function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] t;
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b6;
        int          e;
        t = perm(2, {32'b0, r}, 32, 48);
        x = t[47:0] ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b6 = x[47-6*i -: 6];
            e  = {b6[5], b6[0]} * 16 + b6[4:1];
            s[31-4*i -: 4] = SB_H[i][255-4*e -: 4];
        end
        t = perm(3, {32'b0, s}, 32, 32);
        return t[31:0];
    endfunction

    // Post-IP block in, R16L16 out (all in MSB-first form).
    function automatic logic [63:0] des_core(input logic [63:0] ipb, input logic [63:0] k,
                                             input logic dec);
        logic [63:0] cd, kk;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [31:0] l, r, t;
        cd = perm(4, k, 64, 56);
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            c = (c << SH[n]) | (c >> (28 - SH[n]));
            d = (d << SH[n]) | (d >> (28 - SH[n]));
            kk = perm(5, {8'b0, c, d}, 56, 48);
            ks[n] = kk[47:0];
        end
        l = ipb[63:32];
        r = ipb[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ ffun(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return {r, l};
    endfunction

    function automatic logic [63:0] des(input logic [63:0] blk, input logic [63:0] k,
                                        input logic dec);
        return perm(1, des_core(perm(0, blk, 64, 64), k, dec), 64, 64);
    endfunction

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Cycle-level model: rounds remaining, a pending result, and its value.
    int          m_left;
    logic        m_done, m_fresh;
    logic [63:0] m_pre;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_fresh <= 1'b1;
            m_pre   <= '0;
        end else if (m_left == 0 && !m_done) begin
            if (in_valid) begin
                m_left  <= 16;
                m_fresh <= 1'b0;
                m_pre   <= des_core(rev64(ip_text), rev64(key), decrypt);
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check1("cmp_in_ready", in_ready, m_left == 0 && !m_done);
            check1("cmp_busy", busy, m_left != 0);
            check1("cmp_out_valid", out_valid, m_done);
            if (m_done) check64("cmp_preoutput", rev64(preoutput), m_pre);
            else if (m_fresh) check64("cmp_preoutput_zero", preoutput, 64'h0);
        end
    end

    task automatic run_op(input logic [63:0] blk, input logic [63:0] k, input logic dec,
                          input int stall, output logic [63:0] res);
        int cnt;
        logic [63:0] held;
        @(negedge clk);
        ip_text   = rev64(perm(0, blk, 64, 64));
        key       = rev64(k);
        decrypt   = dec;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        ip_text  = {$urandom, $urandom};
        key      = {$urandom, $urandom};
        decrypt  = ~dec;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        check64("latency", 64'(cnt), 64'd16);
        res = perm(1, rev64(preoutput), 64, 64);
        if (stall > 0) begin
            held = preoutput;
            for (int i = 0; i < stall; i++) begin
                in_valid = i[0];
                ip_text  = {$urandom, $urandom};
                @(negedge clk);
                check64("bp_hold", preoutput, held);
                check1("bp_valid_held", out_valid, 1'b1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check1("bp_idle_ready", in_ready, 1'b1);
            check1("bp_valid_drop", out_valid, 1'b0);
        end
    endtask

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, ct, kx, bx;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; decrypt = 1'b0;
        ip_text = '0; key = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check64("rst_preoutput", preoutput, 64'h0);

        check64("model_kat_enc", des(P1, K1, 1'b0), C1);
        check64("model_kat_dec", des(64'h0, K2, 1'b1), P2);

        run_op(P1, K1, 1'b0, 0, r);  check64("enc_kat", r, C1);
        run_op(C1, K1, 1'b1, 0, r);  check64("dec_kat", r, P1);
        run_op(64'h0, K2, 1'b1, 0, r); check64("dec_kat2", r, P2);
        run_op(P1, K1, 1'b0, 10, r); check64("bp_result", r, C1);

        // Abort mid-RUN: state must fall back to reset values at once.
        @(negedge clk);
        ip_text = rev64(perm(0, P1, 64, 64)); key = rev64(K1); decrypt = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check1("mid_run_busy", busy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check1("abort_out_valid", out_valid, 1'b0);
        check64("abort_preoutput", preoutput, 64'h0);
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_busy", busy, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_op(P1, K1, 1'b0, 0, r);  check64("post_abort_enc", r, C1);

        run_op(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0, 0, r);
        check64("b2b_first", r, des(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0));
        run_op(64'h5A5A5A5AA5A5A5A5, 64'hFFFFFFFF00000000, 1'b0, 0, r);
        check64("b2b_second", r, des(64'h5A5A5A5AA5A5A5A5, 64'hFFFFFFFF00000000, 1'b0));

        for (int i = 0; i < 1000; i++) begin
            kx = {$urandom, $urandom};
            bx = {$urandom, $urandom};
            run_op(bx, kx, 1'b0, 0, ct);
            run_op(ct, kx, 1'b1, 0, r);
            check64("roundtrip", r, bx);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
